// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control path: opcode encodings, ALU select
// codes, the sequencer state encoding and instruction field positions.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcode encodings (INSTRUCTION[31:24])
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // ALU SELECT codes
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Instruction field positions (LSB of each byte field)
  localparam int unsigned OPC_LSB = 24;
  localparam int unsigned RD_LSB  = 16;
  localparam int unsigned RT_LSB  = 8;
  localparam int unsigned RS_LSB  = 0;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_decoder.sv
// -----------------------------------------------------------------------------
// cpu_decoder
// Purely combinational opcode decoder shared by the multi-cycle sequencer and
// the pipelined CPU.
// Ports:
//   opcode_i   8-bit opcode
//   alu_op_o   ALU SELECT code
//   imm_sel_o  1 = ALU DATA2 takes the immediate
//   neg_sel_o  1 = ALU DATA2 takes the two's complement of the operand
//   legal_o    1 = opcode is defined
// -----------------------------------------------------------------------------
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [2:0] alu_op_o,
  output logic       imm_sel_o,
  output logic       neg_sel_o,
  output logic       legal_o
);

  // Opcode to control mapping; undefined opcodes decode to a harmless forward.
  always_comb begin
    alu_op_o  = ALU_FWD;
    imm_sel_o = 1'b0;
    neg_sel_o = 1'b0;
    legal_o   = 1'b1;
    case (opcode_i)
      OP_LOADI: imm_sel_o = 1'b1;
      OP_MOV:   alu_op_o  = ALU_FWD;
      OP_ADD:   alu_op_o  = ALU_ADD;
      OP_SUB: begin
        alu_op_o  = ALU_ADD;
        neg_sel_o = 1'b1;
      end
      OP_AND:   alu_op_o  = ALU_AND;
      OP_OR:    alu_op_o  = ALU_OR;
      default:  legal_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle fetch/decode/execute/writeback sequencer in front of the 8-bit
// ALU and register file. Every output is a flop.
// Ports:
//   CLK, RESET_N            clock, synchronous active-low reset
//   PC                      address of the instruction being fetched/executed
//   INSTR_REQ / INSTR_READY fetch handshake, INSTRUCTION valid with READY
//   READREG1/2, WRITEREG    register file addresses (low 3 bits of fields)
//   WRITEENABLE             one-cycle register write strobe
//   ALUOP, IMM_SEL, NEG_SEL ALU controls, IMMEDIATE operand
//   ILLEGAL                 one-cycle pulse for an undefined opcode
// -----------------------------------------------------------------------------
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned            PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter int unsigned            EXEC_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  output logic [PC_WIDTH-1:0] PC,
  output logic                INSTR_REQ,
  input  logic                INSTR_READY,
  input  logic [31:0]         INSTRUCTION,
  output logic [2:0]          READREG1,
  output logic [2:0]          READREG2,
  output logic [2:0]          WRITEREG,
  output logic                WRITEENABLE,
  output logic [2:0]          ALUOP,
  output logic                IMM_SEL,
  output logic                NEG_SEL,
  output logic [7:0]          IMMEDIATE,
  output logic                ILLEGAL
);

  // Counter preload: the EXECUTE entry cycle counts as the first cycle.
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                req_q, req_d;
  logic [2:0]          rr1_q, rr1_d;
  logic [2:0]          rr2_q, rr2_d;
  logic [2:0]          wr_q, wr_d;
  logic                we_q, we_d;
  logic [2:0]          aluop_q, aluop_d;
  logic                imm_sel_q, imm_sel_d;
  logic                neg_sel_q, neg_sel_d;
  logic [7:0]          imm_q, imm_d;
  logic                ill_q, ill_d;
  logic                legal_q, legal_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [2:0]          dec_alu_op_s;
  logic                dec_imm_sel_s;
  logic                dec_neg_sel_s;
  logic                dec_legal_s;

  // Upper bits of the register fields are architecturally ignored.
  logic                unused_fields_s;
  assign unused_fields_s = ^{INSTRUCTION[RD_LSB+3 +: 5], INSTRUCTION[RT_LSB+3 +: 5]};

  cpu_decoder u_decoder (
    .opcode_i  (INSTRUCTION[OPC_LSB +: 8]),
    .alu_op_o  (dec_alu_op_s),
    .imm_sel_o (dec_imm_sel_s),
    .neg_sel_o (dec_neg_sel_s),
    .legal_o   (dec_legal_s)
  );

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so that the registered outputs line up with the state register.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = 1'b0;
    rr1_d     = rr1_q;
    rr2_d     = rr2_q;
    wr_d      = wr_q;
    we_d      = 1'b0;
    aluop_d   = aluop_q;
    imm_sel_d = imm_sel_q;
    neg_sel_d = neg_sel_q;
    imm_d     = imm_q;
    ill_d     = 1'b0;
    legal_d   = legal_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
      ST_FETCH: begin
        if (INSTR_READY) begin
          // Handshake completes: capture the decoded instruction fields.
          state_d   = ST_DECODE;
          rr1_d     = INSTRUCTION[RT_LSB +: 3];
          rr2_d     = INSTRUCTION[RS_LSB +: 3];
          wr_d      = INSTRUCTION[RD_LSB +: 3];
          imm_d     = INSTRUCTION[RS_LSB +: 8];
          aluop_d   = dec_alu_op_s;
          imm_sel_d = dec_imm_sel_s;
          neg_sel_d = dec_neg_sel_s;
          legal_d   = dec_legal_s;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (legal_q) begin
          state_d = ST_EXECUTE;
          cnt_d   = EXEC_LOAD;
        end else begin
          // Undefined opcode skips EXECUTE and only flags ILLEGAL.
          state_d = ST_WRITEBACK;
          ill_d   = 1'b1;
        end
      end
      ST_EXECUTE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_WRITEBACK;
          we_d    = legal_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        pc_d    = pc_q + PC_WIDTH'(4);
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_RESET;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      rr1_q     <= 3'd0;
      rr2_q     <= 3'd0;
      wr_q      <= 3'd0;
      we_q      <= 1'b0;
      aluop_q   <= 3'd0;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      imm_q     <= 8'd0;
      ill_q     <= 1'b0;
      legal_q   <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      rr1_q     <= rr1_d;
      rr2_q     <= rr2_d;
      wr_q      <= wr_d;
      we_q      <= we_d;
      aluop_q   <= aluop_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      imm_q     <= imm_d;
      ill_q     <= ill_d;
      legal_q   <= legal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PC          = pc_q;
  assign INSTR_REQ   = req_q;
  assign READREG1    = rr1_q;
  assign READREG2    = rr2_q;
  assign WRITEREG    = wr_q;
  assign WRITEENABLE = we_q;
  assign ALUOP       = aluop_q;
  assign IMM_SEL     = imm_sel_q;
  assign NEG_SEL     = neg_sel_q;
  assign IMMEDIATE   = imm_q;
  assign ILLEGAL     = ill_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Table-driven directed bench for cpu_control_fsm plus hand-written reset
// sequences. A second instance with RESET_PC near the top of the address space
// shares all inputs and exercises the silent PC wrap.
// -----------------------------------------------------------------------------
module tb_cpu_control_fsm;

  logic        CLK;
  logic        RESET_N;
  logic        INSTR_READY;
  logic [31:0] INSTRUCTION;

  logic [31:0] PC, PC2;
  logic        INSTR_REQ, INSTR_REQ2;
  logic [2:0]  READREG1, READREG2, WRITEREG;
  logic [2:0]  READREG1_2, READREG2_2, WRITEREG_2;
  logic        WRITEENABLE, WRITEENABLE2;
  logic [2:0]  ALUOP, ALUOP2;
  logic        IMM_SEL, IMM_SEL2, NEG_SEL, NEG_SEL2;
  logic [7:0]  IMMEDIATE, IMMEDIATE2;
  logic        ILLEGAL, ILLEGAL2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_pc2;

  cpu_control_fsm dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC(PC), .INSTR_REQ(INSTR_REQ),
    .INSTR_READY(INSTR_READY), .INSTRUCTION(INSTRUCTION),
    .READREG1(READREG1), .READREG2(READREG2), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .IMMEDIATE(IMMEDIATE), .ILLEGAL(ILLEGAL)
  );

  cpu_control_fsm #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK(CLK), .RESET_N(RESET_N), .PC(PC2), .INSTR_REQ(INSTR_REQ2),
    .INSTR_READY(INSTR_READY), .INSTRUCTION(INSTRUCTION),
    .READREG1(READREG1_2), .READREG2(READREG2_2), .WRITEREG(WRITEREG_2),
    .WRITEENABLE(WRITEENABLE2), .ALUOP(ALUOP2), .IMM_SEL(IMM_SEL2),
    .NEG_SEL(NEG_SEL2), .IMMEDIATE(IMMEDIATE2), .ILLEGAL(ILLEGAL2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    int          delay;
    logic [2:0]  aluop;
    logic        imm_sel;
    logic        neg_sel;
    logic [2:0]  rr1;
    logic [2:0]  rr2;
    logic [2:0]  wr;
    logic [7:0]  imm;
    logic        legal;
  } vec_t;

  vec_t vecs[8];

  // One rising edge passes; outputs are then sampled on the falling edge.
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one instruction starting from a FETCH cycle and returns at the next FETCH.
  task automatic run_instr(input vec_t v);
    int req_cycles;
    int n;
    int we_cnt;
    int ill_cnt;
    int we_idx;
    int ill_idx;
    bit stable;
    check("pc_at_fetch", PC, exp_pc);
    check("pc_wrap_at_fetch", PC2, exp_pc2);
    INSTRUCTION = v.instr;
    req_cycles = 0;
    for (int d = 0; d <= v.delay; d++) begin
      if (INSTR_REQ) req_cycles++;
      INSTR_READY = (d == v.delay);
      step();
    end
    // READY held high with junk outside FETCH must not disturb anything.
    INSTR_READY = 1'b1;
    INSTRUCTION = 32'hDEAD_BEEF;
    check("req_cycles", req_cycles, v.delay + 1);
    check("req_in_decode", {31'd0, INSTR_REQ}, 32'd0);
    check("aluop", {29'd0, ALUOP}, {29'd0, v.aluop});
    check("imm_sel", {31'd0, IMM_SEL}, {31'd0, v.imm_sel});
    check("neg_sel", {31'd0, NEG_SEL}, {31'd0, v.neg_sel});
    check("readreg1", {29'd0, READREG1}, {29'd0, v.rr1});
    check("readreg2", {29'd0, READREG2}, {29'd0, v.rr2});
    check("writereg", {29'd0, WRITEREG}, {29'd0, v.wr});
    check("immediate", {24'd0, IMMEDIATE}, {24'd0, v.imm});
    n = 0; we_cnt = 0; ill_cnt = 0; we_idx = -1; ill_idx = -1; stable = 1'b1;
    while (!INSTR_REQ && n < 20) begin
      if (WRITEENABLE) begin we_cnt++; we_idx = n; end
      if (ILLEGAL) begin ill_cnt++; ill_idx = n; end
      if ({ALUOP, IMM_SEL, NEG_SEL, READREG1, READREG2, WRITEREG, IMMEDIATE} !==
          {v.aluop, v.imm_sel, v.neg_sel, v.rr1, v.rr2, v.wr, v.imm}) stable = 1'b0;
      step();
      n++;
    end
    INSTR_READY = 1'b0;
    check("decode_to_fetch_cycles", n, v.legal ? 4 : 2);
    check("we_count", we_cnt, v.legal ? 1 : 0);
    check("we_cycle", we_idx, v.legal ? 3 : -1);
    check("illegal_count", ill_cnt, v.legal ? 0 : 1);
    check("illegal_cycle", ill_idx, v.legal ? -1 : 1);
    check("controls_stable", {31'd0, stable}, 32'd1);
    exp_pc  = exp_pc + 32'd4;
    exp_pc2 = exp_pc2 + 32'd4;
    check("pc_advance", PC, exp_pc);
    check("pc_wrap_advance", PC2, exp_pc2);
  endtask

  initial begin
    //            instr          dly aluop   imm  neg  rr1   rr2   wr    imm    legal
    vecs[0] = '{32'h0004_0005, 0, 3'b000, 1'b1, 1'b0, 3'd0, 3'd5, 3'd4, 8'h05, 1'b1};
    vecs[1] = '{32'h0201_0203, 3, 3'b001, 1'b0, 1'b0, 3'd2, 3'd3, 3'd1, 8'h03, 1'b1};
    vecs[2] = '{32'h0305_0607, 0, 3'b001, 1'b0, 1'b1, 3'd6, 3'd7, 3'd5, 8'h07, 1'b1};
    vecs[3] = '{32'h0700_0000, 0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0};
    vecs[4] = '{32'h04FB_FAF9, 0, 3'b010, 1'b0, 1'b0, 3'd2, 3'd1, 3'd3, 8'hF9, 1'b1};
    vecs[5] = '{32'h0500_0102, 1, 3'b011, 1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 8'h02, 1'b1};
    vecs[6] = '{32'h0107_0605, 2, 3'b000, 1'b0, 1'b0, 3'd6, 3'd5, 3'd7, 8'h05, 1'b1};
    vecs[7] = '{32'hFF12_3456, 0, 3'b000, 1'b0, 1'b0, 3'd4, 3'd6, 3'd2, 8'h56, 1'b0};

    RESET_N = 1'b0;
    INSTR_READY = 1'b0;
    INSTRUCTION = 32'd0;
    exp_pc  = 32'd0;
    exp_pc2 = 32'hFFFF_FFFC;

    // Reset held for two edges.
    step();
    step();
    check("rst_pc", PC, 32'd0);
    check("rst_pc_wrap", PC2, 32'hFFFF_FFFC);
    check("rst_req", {31'd0, INSTR_REQ}, 32'd0);
    check("rst_we", {31'd0, WRITEENABLE}, 32'd0);
    check("rst_illegal", {31'd0, ILLEGAL}, 32'd0);
    check("rst_aluop", {29'd0, ALUOP}, 32'd0);
    RESET_N = 1'b1;
    step();
    check("req_after_release", {31'd0, INSTR_REQ}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i]);
    end

    // Reset during the second EXECUTE cycle of an add discards the write.
    INSTRUCTION = 32'h0201_0203;
    INSTR_READY = 1'b1;
    step();
    INSTR_READY = 1'b0;
    step();
    step();
    check("mid_exec_aluop_before_rst", {29'd0, ALUOP}, 32'd1);
    check("mid_exec_we_before_rst", {31'd0, WRITEENABLE}, 32'd0);
    RESET_N = 1'b0;
    step();
    check("mid_rst_pc", PC, 32'd0);
    check("mid_rst_pc_wrap", PC2, 32'hFFFF_FFFC);
    check("mid_rst_outputs",
          {24'd0, INSTR_REQ, WRITEENABLE, ILLEGAL, IMM_SEL, NEG_SEL, 3'd0},
          32'd0);
    check("mid_rst_fields", {8'd0, ALUOP, READREG1, READREG2, WRITEREG, IMMEDIATE}, 32'd0);
    RESET_N = 1'b1;
    step();
    check("mid_rst_refetch_req", {31'd0, INSTR_REQ}, 32'd1);
    check("mid_rst_refetch_we", {31'd0, WRITEENABLE}, 32'd0);
    exp_pc  = 32'd0;
    exp_pc2 = 32'hFFFF_FFFC;
    run_instr(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
